// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS core.
// Also carries the madd/msub partial accumulate state that EX reads back while stalled.
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic                ex_reg_we,
  input  logic [DATA_W-1:0]   ex_alu_res,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic                mem_reg_we,
  output logic [DATA_W-1:0]   mem_alu_res,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BUBBLE = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_t;

  mode_t mode_s;

  // Decode the EX/MEM stall pair; the unreachable s3=0,s4=1 case is folded into HOLD.
  always_comb begin
    mode_s = MODE_HOLD;
    case ({stall[4], stall[3]})
      2'b00:   mode_s = MODE_PASS;
      2'b01:   mode_s = MODE_BUBBLE;
      2'b11:   mode_s = MODE_HOLD;
      2'b10:   mode_s = MODE_HOLD;
      default: mode_s = MODE_HOLD;
    endcase
  end

  // Pipeline slot and accumulate-state registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_waddr   <= {ADDR_W{1'b0}};
      mem_reg_we  <= 1'b0;
      mem_alu_res <= {DATA_W{1'b0}};
      mem_hi      <= {DATA_W{1'b0}};
      mem_lo      <= {DATA_W{1'b0}};
      mem_whilo   <= 1'b0;
      mem_valid   <= 1'b0;
      hilo_temp_o <= {(2*DATA_W){1'b0}};
      cnt_o       <= 2'd0;
    end else begin
      case (mode_s)
        MODE_PASS: begin
          mem_waddr   <= ex_waddr;
          mem_reg_we  <= ex_reg_we;
          mem_alu_res <= ex_alu_res;
          mem_hi      <= ex_hi;
          mem_lo      <= ex_lo;
          mem_whilo   <= ex_whilo;
          mem_valid   <= 1'b1;
          // The multi-cycle op has retired, so the next one starts from a clean counter.
          hilo_temp_o <= {(2*DATA_W){1'b0}};
          cnt_o       <= 2'd0;
        end
        MODE_BUBBLE: begin
          mem_waddr   <= {ADDR_W{1'b0}};
          mem_reg_we  <= 1'b0;
          mem_alu_res <= {DATA_W{1'b0}};
          mem_hi      <= {DATA_W{1'b0}};
          mem_lo      <= {DATA_W{1'b0}};
          mem_whilo   <= 1'b0;
          mem_valid   <= 1'b0;
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end
        MODE_HOLD: begin
          mem_waddr   <= mem_waddr;
          mem_reg_we  <= mem_reg_we;
          mem_alu_res <= mem_alu_res;
          mem_hi      <= mem_hi;
          mem_lo      <= mem_lo;
          mem_whilo   <= mem_whilo;
          mem_valid   <= mem_valid;
          hilo_temp_o <= hilo_temp_o;
          cnt_o       <= cnt_o;
        end
        default: begin
          mem_waddr   <= mem_waddr;
          mem_reg_we  <= mem_reg_we;
          mem_alu_res <= mem_alu_res;
          mem_hi      <= mem_hi;
          mem_lo      <= mem_lo;
          mem_whilo   <= mem_whilo;
          mem_valid   <= mem_valid;
          hilo_temp_o <= hilo_temp_o;
          cnt_o       <= cnt_o;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg: reset, pass, bubble, hold, flush, illegal stall.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int vectors = 0;
  int miscompares = 0;

  ex_mem_reg #(.DATA_W(32), .ADDR_W(5), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_alu_res(ex_alu_res),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] waddr, input logic we,
                           input logic [31:0] alu, input logic [31:0] hi, input logic [31:0] lo,
                           input logic whilo, input logic valid, input logic [63:0] hilo,
                           input logic [1:0] cnt);
    chk({tag, ".waddr"}, {59'd0, mem_waddr}, {59'd0, waddr});
    chk({tag, ".reg_we"}, {63'd0, mem_reg_we}, {63'd0, we});
    chk({tag, ".alu_res"}, {32'd0, mem_alu_res}, {32'd0, alu});
    chk({tag, ".hi"}, {32'd0, mem_hi}, {32'd0, hi});
    chk({tag, ".lo"}, {32'd0, mem_lo}, {32'd0, lo});
    chk({tag, ".whilo"}, {63'd0, mem_whilo}, {63'd0, whilo});
    chk({tag, ".valid"}, {63'd0, mem_valid}, {63'd0, valid});
    chk({tag, ".hilo_temp"}, hilo_temp_o, hilo);
    chk({tag, ".cnt"}, {62'd0, cnt_o}, {62'd0, cnt});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b000000;
    ex_waddr = 5'd9; ex_reg_we = 1'b1; ex_alu_res = 32'h0000_0055;
    ex_hi = 32'h0000_00AA; ex_lo = 32'h0000_00BB; ex_whilo = 1'b1;
    hilo_temp_i = 64'h1111_2222_3333_4444; cnt_i = 2'd3;

    // Reset held two cycles with live inputs.
    step();
    check_all("reset1", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    step();
    check_all("reset2", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);

    rst = 1'b0; ex_waddr = 5'd3; ex_alu_res = 32'h0000_1234;
    step();
    check_all("first_pass", 5'd3, 1'b1, 32'h0000_1234, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);

    for (int i = 1; i <= 4; i++) begin
      ex_alu_res = i;
      step();
      chk("stream.alu_res", {32'd0, mem_alu_res}, i);
      chk("stream.valid", {63'd0, mem_valid}, 64'd1);
    end

    // Bubble captures partial accumulate state.
    stall = 6'b001111; ex_waddr = 5'd7; hilo_temp_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
    step();
    check_all("bubble", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'hDEAD_BEEF_0000_0001, 2'd1);
    stall = 6'b000000; cnt_i = 2'd2; ex_waddr = 5'd8; ex_alu_res = 32'h0000_0077;
    step();
    check_all("bubble_release", 5'd8, 1'b1, 32'h0000_0077, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);

    // Hold keeps accumulate state while EX inputs change.
    stall = 6'b001111; hilo_temp_i = 64'hABCD_0000_0000_1234; cnt_i = 2'd2;
    step();
    check_all("bubble2", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'hABCD_0000_0000_1234, 2'd2);
    stall = 6'b011111; hilo_temp_i = 64'd0; cnt_i = 2'd0;
    step();
    check_all("hold_acc", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'hABCD_0000_0000_1234, 2'd2);
    stall = 6'b000000; ex_alu_res = 32'h0000_0099; ex_waddr = 5'd9;
    step();
    check_all("hold_acc_release", 5'd9, 1'b1, 32'h0000_0099, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);

    ex_alu_res = 32'hCAFE_F00D; ex_waddr = 5'd10;
    step();
    check_all("cafe_load", 5'd10, 1'b1, 32'hCAFE_F00D, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_alu_res = 32'h0000_1000 + i;
      ex_waddr = 5'd20 + 5'(i);
      step();
      check_all("cafe_hold", 5'd10, 1'b1, 32'hCAFE_F00D, 32'h0000_00AA, 32'h0000_00BB,
                1'b1, 1'b1, 64'd0, 2'd0);
    end
    stall = 6'b000000; ex_alu_res = 32'h0000_2000; ex_waddr = 5'd12;
    step();
    check_all("cafe_release", 5'd12, 1'b1, 32'h0000_2000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);

    // Stall bits other than 3 and 4 have no effect.
    stall = 6'b100111; ex_alu_res = 32'h0000_3000; ex_waddr = 5'd13;
    step();
    check_all("ignore_pass", 5'd13, 1'b1, 32'h0000_3000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);
    stall = 6'b101000; hilo_temp_i = 64'h0000_0000_0000_5555; cnt_i = 2'd3;
    step();
    check_all("ignore_bubble", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'h0000_0000_0000_5555, 2'd3);

    // Flush beats stall.
    stall = 6'b000000; ex_alu_res = 32'h0000_4000; ex_waddr = 5'd14;
    step();
    check_all("pre_flush", 5'd14, 1'b1, 32'h0000_4000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);
    flush = 1'b1; stall = 6'b001111; cnt_i = 2'd1;
    step();
    check_all("flush_bubble", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    flush = 1'b0; hilo_temp_i = 64'h0000_0000_0000_6666; cnt_i = 2'd2;
    step();
    check_all("pre_flush_hold", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'h0000_0000_0000_6666, 2'd2);
    flush = 1'b1; stall = 6'b011111;
    step();
    check_all("flush_hold", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    flush = 1'b0;

    // Reset together with flush.
    stall = 6'b000000; ex_alu_res = 32'h0000_5000; ex_waddr = 5'd15;
    step();
    check_all("pre_rst_flush", 5'd15, 1'b1, 32'h0000_5000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);
    rst = 1'b1; flush = 1'b1; stall = 6'b001111; cnt_i = 2'd1;
    step();
    check_all("rst_flush", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    rst = 1'b0; flush = 1'b0;

    // Reset in the middle of a hold.
    stall = 6'b000000; ex_alu_res = 32'h0000_6000; ex_waddr = 5'd16;
    step();
    stall = 6'b011111; ex_alu_res = 32'h0000_6001;
    step();
    check_all("mid_hold", 5'd16, 1'b1, 32'h0000_6000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);
    rst = 1'b1;
    step();
    check_all("rst_in_hold", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    rst = 1'b0;

    // Illegal s3=0,s4=1 behaves as hold.
    stall = 6'b000000; ex_alu_res = 32'h0000_7000; ex_waddr = 5'd17;
    step();
    stall = 6'b010000;
    for (int i = 1; i <= 2; i++) begin
      ex_alu_res = 32'h0000_7000 + i;
      ex_waddr = 5'd25;
      step();
      check_all("illegal_hold", 5'd17, 1'b1, 32'h0000_7000, 32'h0000_00AA, 32'h0000_00BB,
                1'b1, 1'b1, 64'd0, 2'd0);
    end
    stall = 6'b001111; hilo_temp_i = 64'h0000_0000_0000_7777; cnt_i = 2'd3;
    step();
    stall = 6'b010000; hilo_temp_i = 64'd0; cnt_i = 2'd0;
    step();
    check_all("illegal_hold_acc", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0,
              64'h0000_0000_0000_7777, 2'd3);
    stall = 6'b000000; ex_alu_res = 32'h0000_8000; ex_waddr = 5'd18;
    step();
    check_all("final_pass", 5'd18, 1'b1, 32'h0000_8000, 32'h0000_00AA, 32'h0000_00BB,
              1'b1, 1'b1, 64'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Latches EX results: destination address, write enable, ALU result, and HI/LO write data.
- Under the global stall vector, either passes data, inserts a bubble, or holds.
- Also holds the multi-cycle accumulate state (hilo_temp, cnt) that EX needs across stalled cycles for madd/msub, and feeds it back to EX.

Parameters:
- DATA_W, 32, general-purpose register / ALU result width
- ADDR_W, 5, register-file address width
- STALL_W, 6, width of the global stall vector (pc, if, id, ex, mem, wb)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  global stall vector; bit3 = EX stalled, bit4 = MEM stalled
- flush  in  1  exception flush; kills the in-flight EX instruction
- ex_waddr  in  ADDR_W  EX destination register address
- ex_reg_we  in  1  EX register write enable
- ex_alu_res  in  DATA_W  EX ALU result
- ex_hi  in  DATA_W  EX HI write data
- ex_lo  in  DATA_W  EX LO write data
- ex_whilo  in  1  EX HI/LO write enable
- hilo_temp_i  in  2*DATA_W  EX partial accumulate product
- cnt_i  in  2  EX multi-cycle step counter
- mem_waddr  out  ADDR_W  registered destination address
- mem_reg_we  out  1  registered write enable
- mem_alu_res  out  DATA_W  registered ALU result
- mem_hi  out  DATA_W  registered HI data
- mem_lo  out  DATA_W  registered LO data
- mem_whilo  out  1  registered HI/LO write enable
- mem_valid  out  1  1 = slot holds a real instruction, 0 = bubble
- hilo_temp_o  out  2*DATA_W  held accumulate product, fed back to EX
- cnt_o  out  2  held step counter, fed back to EX

Behaviour:
- All outputs are registered. Latency is 1 cycle from ex_* to mem_*. No combinational path from inputs to outputs.
- Reset: on a rising edge with rst=1, every output is cleared to 0, including mem_valid, hilo_temp_o and cnt_o.
- Priority per edge: rst > flush > stall decode > normal pass.
- flush=1 (rst=0):
  - Pipeline outputs become a bubble: all mem_* = 0, mem_valid = 0.
  - hilo_temp_o = 0 and cnt_o = 0, regardless of stall.
- Stall decode, with s3 = stall[3] and s4 = stall[4]:
  - PASS (s3=0):
    - mem_* <= ex_*; mem_valid <= 1.
    - hilo_temp_o <= 0; cnt_o <= 0 (the multi-cycle op has completed).
  - BUBBLE (s3=1, s4=0):
    - EX is stalled but MEM advances, so a bubble is inserted.
    - mem_* <= 0; mem_valid <= 0.
    - hilo_temp_o <= hilo_temp_i; cnt_o <= cnt_i (partial state captured).
  - HOLD (s3=1, s4=1):
    - All outputs keep their value, including hilo_temp_o and cnt_o.
  - s3=0, s4=1 cannot be produced by the stall controller. If it occurs, treat it as HOLD; it must never corrupt held data.
- A bubble has mem_reg_we = 0 and mem_whilo = 0, so a bubble never writes architectural state.
- stall bits other than 3 and 4 are ignored.
- Back-to-back multi-cycle operations:
  - cnt_o is 0 after every PASS, so the next madd/msub starts from cnt=0.
  - A flush mid-operation clears cnt_o. The restarted instruction starts clean.
- rst asserted mid-HOLD clears everything on that edge. The hold does not persist through reset.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero ex_* inputs -> all outputs 0, mem_valid=0. On the first edge after rst drops with stall=0, outputs show ex_*, e.g. ex_waddr=5'd3, ex_alu_res=32'h0000_1234, mem_valid=1.
- Pass stream: 4 consecutive ALU results 32'h1, 32'h2, 32'h3, 32'h4 with stall=0 -> mem_alu_res matches each value exactly 1 cycle later; mem_valid stays 1.
- Bubble insertion: stall=6'b001111 for 1 cycle with ex_reg_we=1, ex_waddr=7, hilo_temp_i=64'hDEAD_BEEF_0000_0001, cnt_i=1 -> next cycle mem_reg_we=0, mem_waddr=0, mem_valid=0, hilo_temp_o=64'hDEAD_BEEF_0000_0001, cnt_o=1. Then stall=0 with cnt_i=2 -> PASS; mem_* takes ex_*, hilo_temp_o=0, cnt_o=0.
- Hold: load mem_alu_res=32'hCAFE_F00D, then stall=6'b011111 for 3 cycles while ex_alu_res changes each cycle -> all outputs stay fixed at 32'hCAFE_F00D. On release, the current ex_* is taken.
- Flush priority: flush=1 together with stall=6'b001111 and cnt_i=1 -> all outputs 0, cnt_o=0, mem_valid=0. Repeat with flush=1 and rst=1 -> same result (reset wins).
- Illegal stall: stall=6'b010000 -> outputs hold their previous values for every cycle it is applied; no X on any output.
